// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_pkg
//   Shared types for the multi-cycle shift sequencer.
//   shmode_t  : shift mode as carried on the mode bus (SH_RSVD behaves as logical)
//   shstate_t : sequencer FSM state
// ---------------------------------------------------------------------------
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        SH_LOG   = 2'b00,
        SH_ARITH = 2'b01,
        SH_ROT   = 2'b10,
        SH_RSVD  = 2'b11
    } shmode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shstate_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Request/result bundle between the input logic (master) and the shift
//   sequencer (slave).
//   start  : request, sampled by the sequencer only in IDLE or DONE
//   dir    : 0 = right (toward bit 0), 1 = left
//   mode   : 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   amount : total bit positions to shift
//   din    : word loaded on an accepted start
//   q      : working / result register
//   carry  : last bit shifted or rotated out
//   busy   : high while shifting
//   done   : one-cycle pulse when q holds the final result
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
);

    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CW-1:0]    amount;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, mode, amount, din,
        input  q, carry, busy, done
    );

    modport slave (
        input  start, dir, mode, amount, din,
        output q, carry, busy, done
    );

endinterface

// File: rtl/shift_sequencer_step.sv
// ---------------------------------------------------------------------------
// shift_sequencer_step
//   Combinational single-position shift of a WIDTH-bit word.
//   i_q     : word before this step
//   i_dir   : 0 = right, 1 = left
//   i_mode  : fill rule (logical / arithmetic / rotate; reserved = logical)
//   o_q     : word after this step
//   o_carry : bit that left the word on this step
// ---------------------------------------------------------------------------
module shift_sequencer_step
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir,
    input  shmode_t          i_mode,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry
);

    logic w_fill;

    always_comb begin
        w_fill  = 1'b0;
        o_q     = i_q;
        o_carry = 1'b0;
        if (i_dir) begin
            // Left: arithmetic fills like logical, only rotate re-enters the MSB.
            o_carry = i_q[WIDTH-1];
            if (i_mode == SH_ROT) begin
                w_fill = i_q[WIDTH-1];
            end
            o_q = {i_q[WIDTH-2:0], w_fill};
        end else begin
            o_carry = i_q[0];
            case (i_mode)
                SH_ARITH: w_fill = i_q[WIDTH-1];
                SH_ROT:   w_fill = i_q[0];
                default:  w_fill = 1'b0;
            endcase
            o_q = {w_fill, i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Clocked multi-cycle shifter. Loads a WIDTH-bit word on an accepted start
//   and shifts it by the requested amount, up to STEP positions per clock,
//   in logical, arithmetic or rotate mode in either direction.
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   io_bus : request/result bundle (slave side), see shift_sequencer_if
// ---------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      CW        = $clog2(WIDTH) + 1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'('hAA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    shift_sequencer_if.slave   io_bus
);

    localparam logic [CW-1:0] STEP_CW = CW'(STEP);

    shstate_t         r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_rem;
    logic             r_dir;
    shmode_t          r_mode;

    // Outputs of each chained step; entry i holds the word shifted i+1 places.
    logic [WIDTH-1:0] w_sel_q [STEP];
    logic             w_sel_c [STEP];

    logic [CW-1:0]    w_n;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_c;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_q;
        logic             w_c;

        if (gi == 0) begin : g_first
            assign w_in = r_q;
        end else begin : g_next
            assign w_in = g_step[gi-1].w_q;
        end

        shift_sequencer_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_q     (w_in),
            .i_dir   (r_dir),
            .i_mode  (r_mode),
            .o_q     (w_q),
            .o_carry (w_c)
        );

        assign w_sel_q[gi] = w_q;
        assign w_sel_c[gi] = w_c;
    end

    // Pick the output of stage n = min(STEP, rem). The carry of that stage is
    // the last bit out, since later stages in the chain are discarded.
    always_comb begin
        w_n      = (r_rem > STEP_CW) ? STEP_CW : r_rem;
        w_next_q = r_q;
        w_next_c = r_carry;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (w_n == CW'(i + 1)) begin
                w_next_q = w_sel_q[i];
                w_next_c = w_sel_c[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_q     <= RESET_VAL;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= SH_LOG;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (io_bus.start) begin
                        r_q     <= io_bus.din;
                        r_carry <= 1'b0;
                        r_rem   <= io_bus.amount;
                        r_dir   <= io_bus.dir;
                        r_mode  <= shmode_t'(io_bus.mode);
                        if (io_bus.amount == '0) begin
                            // Nothing to shift: straight to the result cycle.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    // start is deliberately not looked at here.
                    r_q     <= w_next_q;
                    r_carry <= w_next_c;
                    r_rem   <= r_rem - w_n;
                    if (r_rem == w_n) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.q     = r_q;
    assign io_bus.carry = r_carry;
    assign io_bus.busy  = r_busy;
    assign io_bus.done  = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Drives two sequencers (STEP=1 and STEP=3, WIDTH=8, CW=4) and checks them
//   against a behavioural model of the final result, carry and timing.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(8), .CW(4)) bus1 ();
    shift_sequencer_if #(.WIDTH(8), .CW(4)) bus3 ();

    shift_sequencer #(
        .WIDTH     (8),
        .STEP      (1),
        .CW        (4),
        .RESET_VAL (8'hAA)
    ) u_dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus1)
    );

    shift_sequencer #(
        .WIDTH     (8),
        .STEP      (3),
        .CW        (4),
        .RESET_VAL (8'hAA)
    ) u_dut3 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus3)
    );

    // Final {carry, q} after shifting d by amt, from the arithmetic meaning of
    // each mode rather than step-by-step.
    function automatic logic [8:0] model(input logic [7:0] d, input logic dir,
                                         input logic [1:0] mode, input int amt);
        logic [31:0] t;
        logic [15:0] r2;
        logic [7:0]  rq;
        logic        rc;
        int          r;
        if (amt == 0) return {1'b0, d};
        if (mode == 2'b10) begin
            r  = amt % 8;
            r2 = {d, d};
            if (dir) begin
                r2 = r2 << r;
                rq = r2[15:8];
                rc = d[(8 - r) % 8];
            end else begin
                r2 = r2 >> r;
                rq = r2[7:0];
                rc = d[(amt - 1) % 8];
            end
        end else if (dir) begin
            t  = {24'h0, d} << amt;
            rq = t[7:0];
            rc = t[8];
        end else begin
            t  = (mode == 2'b01) ? {{24{d[7]}}, d} : {24'h0, d};
            rc = t[amt-1];
            t  = t >> amt;
            rq = t[7:0];
        end
        return {rc, rq};
    endfunction

    task automatic drive(input bit use3, input logic s, input logic d, input logic [1:0] m,
                         input logic [3:0] a, input logic [7:0] x);
        if (use3) begin
            bus3.start = s; bus3.dir = d; bus3.mode = m; bus3.amount = a; bus3.din = x;
        end else begin
            bus1.start = s; bus1.dir = d; bus1.mode = m; bus1.amount = a; bus1.din = x;
        end
    endtask

    // Called at a falling edge. Issues one request and waits (bounded) for done.
    // lat = falling edges after the accepting edge until done is seen (0 = timeout).
    task automatic run_op(input bit use3, input logic [7:0] x, input logic d,
                          input logic [1:0] m, input logic [3:0] a,
                          output logic [7:0] q, output logic c, output int nbusy,
                          output int lat);
        drive(use3, 1'b1, d, m, a, x);
        @(negedge clk);
        drive(use3, 1'b0, d, m, a, x);
        nbusy = 0;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            if (use3 ? bus3.busy : bus1.busy) nbusy++;
            if (use3 ? bus3.done : bus1.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        q = use3 ? bus3.q : bus1.q;
        c = use3 ? bus3.carry : bus1.carry;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus1.q, bus1.busy, bus1.done, bus1.carry} !== {8'hAA, 3'b000}) begin
            failures++;
            $display("FAIL reset_dut1 got q=%h busy=%b done=%b carry=%b want q=aa 0 0 0",
                     bus1.q, bus1.busy, bus1.done, bus1.carry);
        end
        checks++;
        if ({bus3.q, bus3.busy, bus3.done, bus3.carry} !== {8'hAA, 3'b000}) begin
            failures++;
            $display("FAIL reset_dut3 got q=%h busy=%b done=%b carry=%b want q=aa 0 0 0",
                     bus3.q, bus3.busy, bus3.done, bus3.carry);
        end
    endtask

    task automatic test_directed();
        logic [7:0] q;
        logic       c;
        int         nb, lat;
        run_op(1'b0, 8'hAA, 1'b0, 2'b00, 4'd3, q, c, nb, lat);
        checks++;
        if ({c, q} !== {1'b0, 8'h15}) begin
            failures++; $display("FAIL right_log3 got c=%b q=%h want c=0 q=15", c, q);
        end
        checks++;
        if (nb != 3 || lat != 4) begin
            failures++; $display("FAIL right_log3_timing got busy=%0d lat=%0d want 3 4", nb, lat);
        end
        repeat (2) @(negedge clk);
        run_op(1'b0, 8'h96, 1'b0, 2'b01, 4'd2, q, c, nb, lat);
        checks++;
        if ({c, q} !== {1'b1, 8'hE5}) begin
            failures++; $display("FAIL right_arith2 got c=%b q=%h want c=1 q=e5", c, q);
        end
        // Started in the DONE cycle of the previous request.
        run_op(1'b0, 8'h81, 1'b1, 2'b10, 4'd1, q, c, nb, lat);
        checks++;
        if ({c, q, nb, lat} !== {1'b1, 8'h03, 32'd1, 32'd2}) begin
            failures++;
            $display("FAIL b2b_left_rot1 got c=%b q=%h busy=%0d lat=%0d want 1 03 1 2",
                     c, q, nb, lat);
        end
        run_op(1'b0, 8'h5C, 1'b0, 2'b00, 4'd0, q, c, nb, lat);
        checks++;
        if ({c, q, nb, lat} !== {1'b0, 8'h5C, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL amt0 got c=%b q=%h busy=%0d lat=%0d want 0 5c 0 1", c, q, nb, lat);
        end
        run_op(1'b0, 8'hFF, 1'b1, 2'b00, 4'd10, q, c, nb, lat);
        checks++;
        if ({c, q, nb, lat} !== {1'b0, 8'h00, 32'd10, 32'd11}) begin
            failures++;
            $display("FAIL left_log10 got c=%b q=%h busy=%0d lat=%0d want 0 00 10 11",
                     c, q, nb, lat);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_step3();
        logic [7:0] q;
        logic       c;
        int         nb, lat;
        run_op(1'b1, 8'hAA, 1'b0, 2'b00, 4'd7, q, c, nb, lat);
        checks++;
        if ({c, q, nb, lat} !== {1'b0, 8'h01, 32'd3, 32'd4}) begin
            failures++;
            $display("FAIL step3_right_log7 got c=%b q=%h busy=%0d lat=%0d want 0 01 3 4",
                     c, q, nb, lat);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [7:0] x;
        logic       d;
        logic [1:0] m;
        int         a, lat;
        logic [8:0] exp;
        x   = 8'($urandom);
        d   = 1'($urandom);
        m   = 2'($urandom);
        a   = $urandom_range(4, 12);
        exp = model(x, d, m, a);
        lat = 0;
        drive(1'b0, 1'b1, d, m, 4'(a), x);
        @(negedge clk);
        drive(1'b0, 1'b0, d, m, 4'(a), x);
        @(negedge clk);
        drive(1'b0, 1'b1, ~d, ~m, 4'd1, ~x);
        @(negedge clk);
        drive(1'b0, 1'b0, ~d, ~m, 4'd1, ~x);
        for (int i = 3; i <= 40; i++) begin
            if (bus1.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if ({bus1.carry, bus1.q, lat} !== {exp, a + 1}) begin
            failures++;
            $display("FAIL start_in_shift got c=%b q=%h lat=%0d want c=%b q=%h lat=%0d",
                     bus1.carry, bus1.q, lat, exp[8], exp[7:0], a + 1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int anomalies = 0;
        drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd6, 8'h3C);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 4'd6, 8'h3C);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd1, 8'hF0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 8'hF0);
        @(negedge clk);
        checks++;
        // 0x3C >> 3 after three edges; a wrongly accepted second start would differ.
        if ({bus1.busy, bus1.q} !== {1'b1, 8'h07}) begin
            failures++;
            $display("FAIL mid_shift got busy=%b q=%h want 1 07", bus1.busy, bus1.q);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus1.q, bus1.busy, bus1.done, bus1.carry} !== {8'hAA, 3'b000}) begin
            failures++;
            $display("FAIL async_reset got q=%h busy=%b done=%b carry=%b want aa 0 0 0",
                     bus1.q, bus1.busy, bus1.done, bus1.carry);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.done || bus1.busy || bus1.q !== 8'hAA) anomalies++;
        end
        checks++;
        if (anomalies != 0) begin
            failures++;
            $display("FAIL after_reset got %0d bad cycles want 0", anomalies);
        end
    endtask

    task automatic test_random();
        bit         use3;
        logic [7:0] x, q;
        logic       d, c;
        logic [1:0] m;
        int         a, gap, nb, lat, steps;
        logic [8:0] exp;
        for (int n = 0; n < 80; n++) begin
            use3  = 1'($urandom);
            x     = 8'($urandom);
            d     = 1'($urandom);
            m     = 2'($urandom);
            a     = $urandom_range(0, 15);
            gap   = $urandom_range(0, 2);
            exp   = model(x, d, m, a);
            steps = use3 ? (a + 2) / 3 : a;
            run_op(use3, x, d, m, 4'(a), q, c, nb, lat);
            checks++;
            if ({c, q} !== exp) begin
                failures++;
                $display("FAIL rand_result[%0d] din=%h dir=%b mode=%b amt=%0d step3=%b got c=%b q=%h want c=%b q=%h",
                         n, x, d, m, a, use3, c, q, exp[8], exp[7:0]);
            end
            checks++;
            if (nb != steps || lat != steps + 1) begin
                failures++;
                $display("FAIL rand_timing[%0d] amt=%0d step3=%b got busy=%0d lat=%0d want %0d %0d",
                         n, a, use3, nb, lat, steps, steps + 1);
            end
            if (gap > 0) begin
                @(negedge clk);
                checks++;
                if (use3 ? ({bus3.done, bus3.busy, bus3.carry, bus3.q} !== {2'b00, exp})
                         : ({bus1.done, bus1.busy, bus1.carry, bus1.q} !== {2'b00, exp})) begin
                    failures++;
                    $display("FAIL rand_hold[%0d] got done/busy/c/q=%b%b%b %h want 00 c=%b q=%h",
                             n, use3 ? bus3.done : bus1.done, use3 ? bus3.busy : bus1.busy,
                             use3 ? bus3.carry : bus1.carry, use3 ? bus3.q : bus1.q,
                             exp[8], exp[7:0]);
                end
                repeat (gap - 1) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_step3();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
